// File: rtl/ram_sp_ctrl.sv
// Single-port synchronous RAM controller: turns a valid/ready read/write request stream into
// registered cs/we/oe/address cycles on a shared tri-state bus, with a turnaround after reads.
module ram_sp_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRdAddr,
    StRdData,
    StTurn
  } state_e;

  state_e                state_q, state_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic                  bus_oe_q, bus_oe_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  acc;

  always_comb begin
    req_ready = (state_q == StIdle) || (state_q == StWrite) || (state_q == StTurn);
  end

  assign acc = req_valid & req_ready;

  // Next state plus request capture; address and write data are frozen at acceptance.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle, StWrite, StTurn: begin
        if (acc) begin
          state_d = req_we ? StWrite : StRdAddr;
          addr_d  = req_addr;
          if (req_we) begin
            wdata_d = req_wdata;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StRdAddr: state_d = StRdData;
      StRdData: state_d = StTurn;
      default:  state_d = StIdle;
    endcase
  end

  // Bus-side controls are decoded from the next state so they are all registered.
  always_comb begin
    cs_d     = (state_d == StWrite) || (state_d == StRdAddr) || (state_d == StRdData);
    we_d     = (state_d == StWrite);
    oe_d     = (state_d == StRdAddr) || (state_d == StRdData);
    bus_oe_d = (state_d == StWrite);
  end

  // Only the RD_DATA cycle carries valid RAM output; the RD_ADDR bus value is stale.
  always_comb begin
    rsp_valid_d = (state_q == StRdData);
    rdata_d     = (state_q == StRdData) ? ram_data : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      bus_oe_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      bus_oe_q    <= bus_oe_d;
      rsp_valid_q <= rsp_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ram_cs    = cs_q;
  assign ram_we    = we_q;
  assign ram_oe    = oe_q;
  assign ram_addr  = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign ram_data  = bus_oe_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Bench for ram_sp_ctrl: behavioural sync RAM on the shared bus, directed latency/turnaround/reset
// sequences, a vector table and a random op stream against an array memory model.
module tb_ram_sp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       ram_cs;
  logic       ram_we;
  logic       ram_oe;
  logic [7:0] ram_addr;
  wire  [7:0] ram_data;

  ram_sp_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_oe   (ram_oe),
    .ram_addr (ram_addr),
    .ram_data (ram_data)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM: registered read word, drives bus while cs&oe.
  logic [7:0] mem [256];
  logic [7:0] ram_dout;
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
    else if (ram_cs) ram_dout <= mem[ram_addr];
  end
  assign ram_data = (ram_cs && ram_oe) ? ram_dout : 8'bz;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int viol_weoe  = 0;
  int viol_drive = 0;

  logic [7:0] model [256];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Response capture and bus invariants, sampled 2ns after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (rsp_valid) got_q.push_back(rsp_rdata);
    if (ram_we && ram_oe) viol_weoe++;
    if (dut.bus_oe_q && ram_oe) viol_drive++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d,
                      output int acc_cyc);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: req_ready low for %0d cycles", n);
    end
    if (we) model[a] = d;
    else exp_q.push_back(model[a]);
    @(negedge clk);
    acc_cyc   = cyc;
    req_valid = 1'b0;
  endtask

  task automatic read_check(input logic [7:0] a, input logic [7:0] e, input string nm);
    int c;
    int n = 0;
    got_q.delete();
    send(1'b0, a, 8'h00, c);
    while (got_q.size() == 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: no rsp_valid within %0d cycles", nm, n);
    end else begin
      check(nm, got_q.pop_front(), e);
    end
  endtask

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int acc_c[4];
    int n;
    logic [7:0] g;
    logic [7:0] e;

    tbl[0] = '{we: 1'b1, addr: 8'h20, wdata: 8'h5a, exp: 8'h00};
    tbl[1] = '{we: 1'b0, addr: 8'h20, wdata: 8'h00, exp: 8'h5a};
    tbl[2] = '{we: 1'b1, addr: 8'h21, wdata: 8'h01, exp: 8'h00};
    tbl[3] = '{we: 1'b1, addr: 8'h21, wdata: 8'h02, exp: 8'h00};
    tbl[4] = '{we: 1'b0, addr: 8'h21, wdata: 8'h00, exp: 8'h02};
    tbl[5] = '{we: 1'b0, addr: 8'h00, wdata: 8'h00, exp: 8'h11};
    tbl[6] = '{we: 1'b1, addr: 8'hff, wdata: 8'hc3, exp: 8'h00};
    tbl[7] = '{we: 1'b0, addr: 8'hff, wdata: 8'h00, exp: 8'hc3};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs", ram_cs, 0);
    check("rst_we", ram_we, 0);
    check("rst_oe", ram_oe, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_bus_released", dut.bus_oe_q, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_ready", req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read: response two edges after the read accept.
    send(1'b1, 8'h10, 8'ha5, c);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h10;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 8'h99;
    check("rdaddr_cs", ram_cs, 1);
    check("rdaddr_oe", ram_oe, 1);
    check("rdaddr_we", ram_we, 0);
    check("rdaddr_addr", ram_addr, 8'h10);
    check("rdaddr_ready", req_ready, 0);
    check("rdaddr_rsp", rsp_valid, 0);
    @(negedge clk);
    check("rddata_rsp", rsp_valid, 0);
    check("rddata_oe", ram_oe, 1);
    check("rddata_addr_held", ram_addr, 8'h10);
    @(negedge clk);
    check("turn_rsp_valid", rsp_valid, 1);
    check("turn_rdata", rsp_rdata, 8'ha5);
    check("turn_cs", ram_cs, 0);
    check("turn_ready", req_ready, 1);
    @(negedge clk);
    check("idle_rsp_drop", rsp_valid, 0);
    check("idle_rdata_held", rsp_rdata, 8'ha5);

    // Four back-to-back writes, then four reads spaced three cycles apart.
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 8'(i);
      req_wdata = 8'((i + 1) * 8'h11);
      check("b2b_ready", req_ready, 1);
      model[i] = 8'((i + 1) * 8'h11);
      @(negedge clk);
      check("b2b_we", ram_we, 1);
      check("b2b_addr", ram_addr, i);
    end
    req_valid = 1'b0;
    @(negedge clk);
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) send(1'b0, 8'(i), 8'h00, acc_c[i]);
    for (int i = 1; i < 4; i++) check("rd_spacing", acc_c[i] - acc_c[i-1], 3);
    n = 0;
    while (got_q.size() < 4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_rsp_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (got_q.size() > 0) check("b2b_rdata", got_q.pop_front(), (i + 1) * 8'h11);
    end

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].we) send(1'b1, tbl[i].addr, tbl[i].wdata, c);
      else read_check(tbl[i].addr, tbl[i].exp, "tbl_read");
    end
    repeat (2) @(negedge clk);

    // Read immediately followed by a write to the same address.
    send(1'b1, 8'h05, 8'h3c, c);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h05;
    @(negedge clk);
    req_we    = 1'b1;
    req_wdata = 8'h77;
    check("rw_rdaddr_oe", ram_oe, 1);
    check("rw_rdaddr_nodrive", dut.bus_oe_q, 0);
    check("rw_rdaddr_ready", req_ready, 0);
    @(negedge clk);
    check("rw_rddata_oe", ram_oe, 1);
    check("rw_rddata_nodrive", dut.bus_oe_q, 0);
    @(negedge clk);
    check("rw_turn_cs", ram_cs, 0);
    check("rw_turn_oe", ram_oe, 0);
    check("rw_turn_bus_z", dut.bus_oe_q, 0);
    check("rw_turn_rsp", rsp_valid, 1);
    check("rw_turn_rdata", rsp_rdata, 8'h3c);
    check("rw_turn_ready", req_ready, 1);
    @(negedge clk);
    model[5]  = 8'h77;
    req_valid = 1'b0;
    check("rw_write_we", ram_we, 1);
    check("rw_write_drive", dut.bus_oe_q, 1);
    check("rw_write_oe", ram_oe, 0);
    check("rw_write_addr", ram_addr, 8'h05);
    read_check(8'h05, 8'h77, "rw_readback");
    repeat (2) @(negedge clk);

    // Reset asserted during RD_DATA drops the read.
    send(1'b1, 8'h30, 8'h99, c);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h30;
    @(negedge clk);
    req_valid = 1'b0;
    got_q.delete();
    @(negedge clk);
    check("rst_mid_in_rddata", ram_oe, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_rsp", rsp_valid, 0);
    check("rst_mid_cs", ram_cs, 0);
    check("rst_mid_oe", ram_oe, 0);
    check("rst_mid_ready", req_ready, 1);
    check("rst_mid_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_no_pulse", rsp_valid, 0);
    check("rst_mid_no_rsp", got_q.size(), 0);
    read_check(8'h30, 8'h99, "rst_mid_readback");
    repeat (2) @(negedge clk);

    // Random op stream on a 16-word window against the array model.
    for (int a = 0; a < 16; a++) send(1'b1, 8'(a), 8'($urandom_range(0, 255)), c);
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 2000; i++) begin
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), c);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    n = 0;
    while (got_q.size() < exp_q.size() && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rand_rsp_count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check("rand_rdata", g, e);
    end

    check("never_we_and_oe", viol_weoe, 0);
    check("never_drive_with_oe", viol_drive, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
